// File: rtl/ahb_timer_mc.sv
// Multi-channel AHB-Lite down-counter timer: shared prescaler, per-channel expiry, maskable irq.
// Optional macro TIMER_ERR_RESP_EN adds a two-cycle ERROR response for illegal accesses.

module ahb_timer_mc #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned PRE_W  = 16
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              HSELx,
  input  logic [31:0]       HADDR,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [1:0]        HTRANS,
  input  logic              HREADY,
  input  logic [31:0]       HWDATA,
  output logic [31:0]       HRDATA,
  output logic              HREADYOUT,
  output logic              HRESP,
  output logic              irq,
  output logic [NUM_CH-1:0] ch_expired
);

  localparam int unsigned AW     = 6;
  localparam logic [31:0] ID_VAL = 32'h544D_4300 | 32'(NUM_CH);

  logic              addr_valid_c;
  logic              acc_err_c;
  logic [AW-1:0]     addr_q, addr_d;
  logic              write_q, write_d;
  logic              valid_q, valid_d;

  logic              gen_q, gen_d;
  logic [PRE_W-1:0]  prescale_q, prescale_d;
  logic [PRE_W-1:0]  pre_cnt_q, pre_cnt_d;
  logic [NUM_CH-1:0] status_q, status_d;
  logic [NUM_CH-1:0] irq_en_q, irq_en_d;
  logic              irq_q, irq_d;
  logic [NUM_CH-1:0] expired_q;

  logic [NUM_CH-1:0] en_q, en_d;
  logic [NUM_CH-1:0] per_q, per_d;
  logic [CNT_W-1:0]  load_q  [NUM_CH];
  logic [CNT_W-1:0]  load_d  [NUM_CH];
  logic [CNT_W-1:0]  value_q [NUM_CH];
  logic [CNT_W-1:0]  value_d [NUM_CH];

  logic              tick_c;
  logic [NUM_CH-1:0] expire_c;
  logic              wr_c, wr_gctrl, wr_pre, wr_status, wr_irqen;
  logic [NUM_CH-1:0] wr_ctrl, wr_load;
  logic [31:0]       rdata_c;

  logic unused_c;
  assign unused_c = ^{HSIZE, HTRANS[0], HADDR[31:8], HADDR[1:0]};

  assign addr_valid_c = HSELx & HREADY & HTRANS[1];

`ifdef TIMER_ERR_RESP_EN
  localparam logic [3:0] CH_END = 4'(NUM_CH + 2);

  typedef enum logic [1:0] {RESP_OK, RESP_ERR1, RESP_ERR2} resp_e;
  resp_e resp_q, resp_d;
  logic  hready_q, hready_d;
  logic  hresp_q, hresp_d;

  // Illegal: unmapped globals, reserved/absent channel slots, writes to ID or VALUE
  always_comb begin
    acc_err_c = 1'b0;
    if (HADDR[7:5] == 3'd0) begin
      if (HADDR[4:2] > 3'd4)                      acc_err_c = 1'b1;
      else if (HADDR[4:2] == 3'd4 && HWRITE)      acc_err_c = 1'b1;
    end else if (HADDR[7:4] >= CH_END) begin
      acc_err_c = 1'b1;
    end else if (HADDR[3:2] == 2'd3) begin
      acc_err_c = 1'b1;
    end else if (HADDR[3:2] == 2'd2 && HWRITE) begin
      acc_err_c = 1'b1;
    end
  end

  always_comb begin
    resp_d = resp_q;
    unique case (resp_q)
      RESP_OK:   if (addr_valid_c && acc_err_c) resp_d = RESP_ERR1;
      RESP_ERR1: resp_d = RESP_ERR2;
      RESP_ERR2: resp_d = (addr_valid_c && acc_err_c) ? RESP_ERR1 : RESP_OK;
      default:   resp_d = RESP_OK;
    endcase
    hready_d = (resp_d != RESP_ERR1);
    hresp_d  = (resp_d != RESP_OK);
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      resp_q   <= RESP_OK;
      hready_q <= 1'b1;
      hresp_q  <= 1'b0;
    end else begin
      resp_q   <= resp_d;
      hready_q <= hready_d;
      hresp_q  <= hresp_d;
    end
  end

  assign HREADYOUT = hready_q;
  assign HRESP     = hresp_q;
`else
  assign acc_err_c = 1'b0;
  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;
`endif

  // Address phase capture; an errored transfer never reaches its data phase
  always_comb begin
    addr_d  = addr_q;
    write_d = write_q;
    valid_d = addr_valid_c & ~acc_err_c;
    if (addr_valid_c) begin
      addr_d  = HADDR[7:2];
      write_d = HWRITE;
    end
  end

  always_comb begin
    wr_c      = valid_q & write_q;
    wr_gctrl  = wr_c && (addr_q == AW'(0));
    wr_pre    = wr_c && (addr_q == AW'(1));
    wr_status = wr_c && (addr_q == AW'(2));
    wr_irqen  = wr_c && (addr_q == AW'(3));
    wr_ctrl   = '0;
    wr_load   = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      wr_ctrl[n] = wr_c && (addr_q[5:2] == 4'(n + 2)) && (addr_q[1:0] == 2'd0);
      wr_load[n] = wr_c && (addr_q[5:2] == 4'(n + 2)) && (addr_q[1:0] == 2'd1);
    end
  end

  // Global control, prescaler and status
  always_comb begin
    gen_d      = wr_gctrl ? HWDATA[0] : gen_q;
    prescale_d = wr_pre ? HWDATA[PRE_W-1:0] : prescale_q;
    irq_en_d   = wr_irqen ? HWDATA[NUM_CH-1:0] : irq_en_q;
    tick_c     = gen_q && (pre_cnt_q == prescale_q);
    if (!gen_q || wr_pre || tick_c) pre_cnt_d = '0;
    else                            pre_cnt_d = pre_cnt_q + PRE_W'(1);
    status_d   = (status_q & ~(wr_status ? HWDATA[NUM_CH-1:0] : NUM_CH'(0))) | expire_c;
    irq_d      = |(status_q & irq_en_q);
  end

  // Channel counters; a LOAD write overrides the tick and suppresses expiry
  always_comb begin
    en_d     = en_q;
    per_d    = per_q;
    load_d   = load_q;
    value_d  = value_q;
    expire_c = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      if (tick_c && en_q[n]) begin
        if (value_q[n] != '0) begin
          value_d[n] = value_q[n] - CNT_W'(1);
        end else begin
          expire_c[n] = 1'b1;
          if (per_q[n]) value_d[n] = load_q[n];
          else          en_d[n]    = 1'b0;
        end
      end
      if (wr_ctrl[n]) begin
        en_d[n]  = HWDATA[0];
        per_d[n] = HWDATA[1];
      end
      if (wr_load[n]) begin
        load_d[n]   = HWDATA[CNT_W-1:0];
        value_d[n]  = HWDATA[CNT_W-1:0];
        expire_c[n] = 1'b0;
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_q     <= '0;
      write_q    <= 1'b0;
      valid_q    <= 1'b0;
      gen_q      <= 1'b0;
      prescale_q <= '0;
      pre_cnt_q  <= '0;
      status_q   <= '0;
      irq_en_q   <= '0;
      irq_q      <= 1'b0;
      expired_q  <= '0;
      en_q       <= '0;
      per_q      <= '0;
      load_q     <= '{default: '0};
      value_q    <= '{default: '0};
    end else begin
      addr_q     <= addr_d;
      write_q    <= write_d;
      valid_q    <= valid_d;
      gen_q      <= gen_d;
      prescale_q <= prescale_d;
      pre_cnt_q  <= pre_cnt_d;
      status_q   <= status_d;
      irq_en_q   <= irq_en_d;
      irq_q      <= irq_d;
      expired_q  <= expire_c;
      en_q       <= en_d;
      per_q      <= per_d;
      load_q     <= load_d;
      value_q    <= value_d;
    end
  end

  // Read mux driven from the registered data-phase address
  always_comb begin
    rdata_c = '0;
    if (valid_q && !write_q) begin
      if (addr_q[5:3] == 3'd0) begin
        case (addr_q[2:0])
          3'd0:    rdata_c = {31'd0, gen_q};
          3'd1:    rdata_c = 32'(prescale_q);
          3'd2:    rdata_c = 32'(status_q);
          3'd3:    rdata_c = 32'(irq_en_q);
          3'd4:    rdata_c = ID_VAL;
          default: rdata_c = '0;
        endcase
      end else begin
        for (int n = 0; n < NUM_CH; n++) begin
          if (addr_q[5:2] == 4'(n + 2)) begin
            case (addr_q[1:0])
              2'd0:    rdata_c = {30'd0, per_q[n], en_q[n]};
              2'd1:    rdata_c = 32'(load_q[n]);
              2'd2:    rdata_c = 32'(value_q[n]);
              default: rdata_c = '0;
            endcase
          end
        end
      end
    end
  end

  assign HRDATA     = rdata_c;
  assign irq        = irq_q;
  assign ch_expired = expired_q;

endmodule

// File: tb/tb_ahb_timer_mc.sv
// Self-checking bench for ahb_timer_mc: register table plus timed countdown/expiry sequences.

module tb_ahb_timer_mc;

  localparam int unsigned NUM_CH = 4;
`ifdef TIMER_ERR_RESP_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic              HCLK = 1'b0;
  logic              HRESETn;
  logic              HSELx;
  logic [31:0]       HADDR;
  logic              HWRITE;
  logic [2:0]        HSIZE;
  logic [1:0]        HTRANS;
  logic [31:0]       HWDATA;
  logic [31:0]       HRDATA;
  logic              hreadyout;
  logic              HRESP;
  logic              irq;
  logic [NUM_CH-1:0] ch_expired;

  ahb_timer_mc #(.NUM_CH(NUM_CH), .CNT_W(32), .PRE_W(16)) dut (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .HSELx      (HSELx),
    .HADDR      (HADDR),
    .HWRITE     (HWRITE),
    .HSIZE      (HSIZE),
    .HTRANS     (HTRANS),
    .HREADY     (hreadyout),
    .HWDATA     (HWDATA),
    .HRDATA     (HRDATA),
    .HREADYOUT  (hreadyout),
    .HRESP      (HRESP),
    .irq        (irq),
    .ch_expired (ch_expired)
  );

  always #5 HCLK = ~HCLK;

  int checks   = 0;
  int failures = 0;
  logic [31:0] sb[$];

  int cyc = 0;
  int ch0_pulses = 0;
  int ch1_times[$];

  always @(negedge HCLK) begin
    cyc++;
    if (ch_expired[0]) ch0_pulses++;
    if (ch_expired[1]) ch1_times.push_back(cyc);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic sb_check(input string name, input logic [31:0] act);
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: scoreboard empty, got 0x%08h", name, act);
    end else begin
      check(name, act, sb.pop_front());
    end
  endtask

  task automatic ap(input logic wr, input logic [7:0] a);
    HSELx  = 1'b1;
    HTRANS = 2'b10;
    HWRITE = wr;
    HADDR  = {24'h4000_00, a};
  endtask

  task automatic ap_idle();
    HSELx  = 1'b0;
    HTRANS = 2'b00;
    HWRITE = 1'b0;
  endtask

  task automatic xfer(input logic wr, input logic [7:0] a, input logic [31:0] wd,
                      output logic [31:0] rd, output logic rsp, output int waits);
    @(negedge HCLK);
    ap(wr, a);
    @(negedge HCLK);
    ap_idle();
    HWDATA = wd;
    waits = 0;
    while (!hreadyout && waits < 8) begin
      @(negedge HCLK);
      waits++;
    end
    if (waits >= 8) begin
      checks++;
      failures++;
      $display("FAIL xfer_timeout addr=0x%02h: HREADYOUT stuck low", a);
    end
    rd  = HRDATA;
    rsp = HRESP;
  endtask

  task automatic wr32(input logic [7:0] a, input logic [31:0] d);
    logic [31:0] rd;
    logic rsp;
    int waits;
    xfer(1'b1, a, d, rd, rsp, waits);
  endtask

  task automatic rd_chk(input logic [7:0] a, input logic [31:0] exp, input string name);
    logic [31:0] rd;
    logic rsp;
    int waits;
    sb.push_back(exp);
    xfer(1'b0, a, 32'h0, rd, rsp, waits);
    sb_check(name, rd);
  endtask

  task automatic do_reset();
    HRESETn = 1'b0;
    ap_idle();
    HWDATA = '0;
    sb.delete();
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b1;
    @(negedge HCLK);
  endtask

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs[22];
  logic [31:0] exp_val[6];
  logic [31:0] rd;
  logic        rsp;
  int          waits;
  int          snap;

  initial begin
    vecs[0]  = '{1'b0, 8'h10, 32'h0,         32'h544D_4304};
    vecs[1]  = '{1'b0, 8'h00, 32'h0,         32'h0};
    vecs[2]  = '{1'b0, 8'h08, 32'h0,         32'h0};
    vecs[3]  = '{1'b0, 8'h20, 32'h0,         32'h0};
    vecs[4]  = '{1'b1, 8'h04, 32'h0001_1234, 32'h0};
    vecs[5]  = '{1'b0, 8'h04, 32'h0,         32'h0000_1234};
    vecs[6]  = '{1'b1, 8'h0C, 32'hFFFF_FFFF, 32'h0};
    vecs[7]  = '{1'b0, 8'h0C, 32'h0,         32'h0000_000F};
    vecs[8]  = '{1'b1, 8'h54, 32'hDEAD_BEEF, 32'h0};
    vecs[9]  = '{1'b0, 8'h54, 32'h0,         32'hDEAD_BEEF};
    vecs[10] = '{1'b0, 8'h58, 32'h0,         32'hDEAD_BEEF};
    vecs[11] = '{1'b1, 8'h50, 32'h0000_0007, 32'h0};
    vecs[12] = '{1'b0, 8'h50, 32'h0,         32'h0000_0003};
    vecs[13] = '{1'b0, 8'h5C, 32'h0,         32'h0};
    vecs[14] = '{1'b0, 8'h60, 32'h0,         32'h0};
    vecs[15] = '{1'b1, 8'h64, 32'h0000_1234, 32'h0};
    vecs[16] = '{1'b0, 8'h64, 32'h0,         32'h0};
    vecs[17] = '{1'b0, 8'h14, 32'h0,         32'h0};
    vecs[18] = '{1'b1, 8'h08, 32'h0000_000F, 32'h0};
    vecs[19] = '{1'b0, 8'h08, 32'h0,         32'h0};
    vecs[20] = '{1'b1, 8'h00, 32'hFFFF_FFFF, 32'h0};
    vecs[21] = '{1'b0, 8'h00, 32'h0,         32'h1};
    exp_val  = '{32'd3, 32'd2, 32'd1, 32'd0, 32'd0, 32'd0};

    HRESETn = 1'b0;
    HSIZE   = 3'b010;
    HADDR   = '0;
    HWDATA  = '0;
    ap_idle();
    @(negedge HCLK);
    check("rst_hrdata",    HRDATA, 32'h0);
    check("rst_hreadyout", 32'(hreadyout), 32'h1);
    check("rst_hresp",     32'(HRESP), 32'h0);
    check("rst_irq",       32'(irq), 32'h0);
    check("rst_expired",   32'(ch_expired), 32'h0);
    do_reset();

    // Register table
    for (int i = 0; i < 22; i++) begin
      if (!vecs[i].wr) sb.push_back(vecs[i].exp);
      xfer(vecs[i].wr, vecs[i].addr, vecs[i].data, rd, rsp, waits);
      if (!vecs[i].wr) sb_check($sformatf("vec%0d_rd_0x%02h", i, vecs[i].addr), rd);
    end

    // One-shot countdown with back-to-back VALUE0 reads
    do_reset();
    wr32(8'h04, 32'd0);
    wr32(8'h24, 32'd3);
    wr32(8'h20, 32'd1);
    wr32(8'h0C, 32'd1);
    snap = ch0_pulses;
    @(negedge HCLK); ap(1'b1, 8'h00);
    @(negedge HCLK); HWDATA = 32'd1; ap(1'b0, 8'h28); sb.push_back(exp_val[0]);
    for (int k = 0; k < 6; k++) begin
      @(negedge HCLK);
      sb_check($sformatf("oneshot_value_t%0d", k), HRDATA);
      check($sformatf("oneshot_pulse_t%0d", k), 32'(ch_expired[0]), (k == 4) ? 32'd1 : 32'd0);
      check($sformatf("oneshot_irq_t%0d", k), 32'(irq), (k == 5) ? 32'd1 : 32'd0);
      if (k < 5) begin
        ap(1'b0, 8'h28);
        sb.push_back(exp_val[k+1]);
      end else begin
        ap_idle();
      end
    end
    repeat (4) @(negedge HCLK);
    check("oneshot_pulse_count", 32'(ch0_pulses - snap), 32'd1);
    rd_chk(8'h08, 32'h1, "oneshot_status");
    rd_chk(8'h20, 32'h0, "oneshot_ctrl_en_clr");
    rd_chk(8'h28, 32'h0, "oneshot_value_hold");
    check("oneshot_irq_hold", 32'(irq), 32'd1);

    // Periodic channel 1 with PRESCALE=2
    do_reset();
    wr32(8'h04, 32'd2);
    wr32(8'h34, 32'd1);
    wr32(8'h30, 32'd3);
    wr32(8'h0C, 32'h2);
    ch1_times.delete();
    wr32(8'h00, 32'd1);
    repeat (40) @(negedge HCLK);
    check("per_irq_high", 32'(irq), 32'd1);
    wr32(8'h00, 32'd0);
    check("per_count_ge5", 32'(ch1_times.size() >= 5), 32'd1);
    for (int i = 1; i < ch1_times.size(); i++)
      check($sformatf("per_interval_%0d", i), 32'(ch1_times[i] - ch1_times[i-1]), 32'd6);
    rd_chk(8'h08, 32'h2, "per_status_set");
    wr32(8'h08, 32'h2);
    rd_chk(8'h08, 32'h0, "per_status_w1c");
    repeat (2) @(negedge HCLK);
    check("per_irq_low", 32'(irq), 32'd0);

    // Same-cycle W1C vs expiry, and LOAD write vs expiry
    do_reset();
    wr32(8'h04, 32'd0);
    wr32(8'h24, 32'd3);
    wr32(8'h20, 32'd3);
    @(negedge HCLK); ap(1'b1, 8'h00);
    @(negedge HCLK); HWDATA = 32'd1; ap_idle();
    repeat (3) @(negedge HCLK); ap(1'b1, 8'h08);
    @(negedge HCLK); HWDATA = 32'd1; ap_idle();
    @(negedge HCLK);
    check("sim_pulse_p6", 32'(ch_expired[0]), 32'd1);
    ap(1'b0, 8'h08); sb.push_back(32'h1);
    @(negedge HCLK);
    sb_check("sim_status_set_wins", HRDATA);
    ap(1'b1, 8'h08);
    @(negedge HCLK); HWDATA = 32'd1; ap(1'b0, 8'h08); sb.push_back(32'h0);
    @(negedge HCLK);
    sb_check("sim_status_cleared", HRDATA);
    ap_idle();
    @(negedge HCLK);
    check("sim_pulse_p10", 32'(ch_expired[0]), 32'd1);
    repeat (2) @(negedge HCLK); ap(1'b1, 8'h24);
    @(negedge HCLK); HWDATA = 32'd5; ap(1'b0, 8'h28); sb.push_back(32'd5);
    @(negedge HCLK);
    sb_check("sim_load_value", HRDATA);
    check("sim_load_nopulse", 32'(ch_expired[0]), 32'd0);
    ap_idle();

    // Global disable freezes the count, re-enable resumes
    do_reset();
    wr32(8'h04, 32'd0);
    wr32(8'h24, 32'd10);
    wr32(8'h20, 32'd1);
    @(negedge HCLK); ap(1'b1, 8'h00);
    @(negedge HCLK); HWDATA = 32'd1; ap_idle();
    @(negedge HCLK);
    @(negedge HCLK); ap(1'b1, 8'h00);
    @(negedge HCLK); HWDATA = 32'd0; ap_idle();
    repeat (4) @(negedge HCLK);
    rd_chk(8'h28, 32'd7, "freeze_hold");
    @(negedge HCLK); ap(1'b1, 8'h00);
    @(negedge HCLK); HWDATA = 32'd1; ap(1'b0, 8'h28); sb.push_back(32'd7);
    for (int k = 0; k < 3; k++) begin
      @(negedge HCLK);
      sb_check($sformatf("resume_value_t%0d", k), HRDATA);
      if (k < 2) begin
        ap(1'b0, 8'h28);
        sb.push_back(32'(6 - k));
      end else begin
        ap_idle();
      end
    end

    // Error-response behaviour (OKAY everywhere when the feature is off)
    do_reset();
    wr32(8'h24, 32'd9);
    xfer(1'b1, 8'h2C, 32'h1234, rd, rsp, waits);
    check("err_rsvd_resp",  32'(rsp), 32'(ERR_EN));
    check("err_rsvd_waits", 32'(waits), 32'(ERR_EN));
    xfer(1'b1, 8'h28, 32'h55, rd, rsp, waits);
    check("err_value_resp", 32'(rsp), 32'(ERR_EN));
    xfer(1'b0, 8'h28, 32'h0, rd, rsp, waits);
    check("err_value_unchanged", rd, 32'd9);
    check("err_value_rd_okay", 32'(rsp), 32'd0);
    xfer(1'b1, 8'h10, 32'h0, rd, rsp, waits);
    check("err_id_wr_resp", 32'(rsp), 32'(ERR_EN));
    rd_chk(8'h10, 32'h544D_4304, "err_id_unchanged");
    xfer(1'b0, 8'h50, 32'h0, rd, rsp, waits);
    check("err_ch3_rd_okay", 32'(rsp), 32'd0);
    check("err_ch3_rd_data", rd, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
